usb_ep_tx_scheduler: RTL and testbench

//  Shares the USB device controller's single IN (transmit) datapath between NUM_EP bulk IN endpoint FIFOs (endpoints 1..NUM_EP).

---
 rtl/usb_ep_tx_scheduler.sv | 143 ++++++++++++++
 tb/tb_usb_ep_tx_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_tx_scheduler.sv
// usb_ep_tx_scheduler: shares the controller's single IN datapath among NUM_EP bulk IN endpoint FIFOs.
// Optional USB_TX_ZLP_EN: queue a zero-length packet after a full-size final packet.
module usb_ep_tx_scheduler #(
   parameter int NUM_EP    = 3,
   parameter int MAXPKT_HS = 512,
   parameter int MAXPKT_FS = 64
) (
   input  logic                 PHY_CLKOUT,
   input  logic                 RESET,
   input  logic                 usbrst_i,
   input  logic                 highspeed_i,
   input  logic [3:0]           endpt_i,
   input  logic                 txact_i,
   input  logic                 txpop_i,
   input  logic                 txpktfin_i,
   input  logic [12*NUM_EP-1:0] ep_level_i,
   input  logic [NUM_EP-1:0]    ep_eot_i,
   input  logic [8*NUM_EP-1:0]  ep_rdat_i,
   output logic [NUM_EP-1:0]    ep_rd_o,
   output logic [7:0]           txdat_o,
   output logic [11:0]          txdat_len_o,
   output logic                 txcork_o,
   output logic                 abort_o,
   output logic                 overpop_o
);
   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
   state_t            r_state;
   logic [3:0]        r_sel;
   logic [11:0]       r_len, r_cnt;
   logic              r_cork, r_abort, r_overpop;
   logic [NUM_EP-1:0] w_zlp_vec;
   logic [11:0]       w_mp, w_lvl, w_len;
   logic              w_ok, w_eot, w_zlp, w_cork, w_pop;
   logic [7:0]        w_dat;
   assign w_mp = highspeed_i ? 12'(MAXPKT_HS) : 12'(MAXPKT_FS);
   always_comb begin
      w_ok  = 1'b0;
      w_lvl = '0;
      w_eot = 1'b0;
      w_zlp = 1'b0;
      w_dat = '0;
      for (int n = 0; n < NUM_EP; n++) begin
         if (endpt_i == 4'(n + 1)) begin
            w_ok  = 1'b1;
            w_lvl = ep_level_i[12*n +: 12];
            w_eot = ep_eot_i[n];
            w_zlp = w_zlp_vec[n];
         end
         if (r_sel == 4'(n + 1))
            w_dat = ep_rdat_i[8*n +: 8];
      end
   end
   assign w_len  = (!w_ok || w_zlp) ? 12'd0 : (w_lvl > w_mp ? w_mp : w_lvl);
   assign w_cork = !w_ok || (!w_zlp && (w_lvl == 12'd0 || (w_lvl < w_mp && !w_eot)));
   assign w_pop  = r_state == SEND && txpop_i && r_cnt < r_len;
   always_comb begin
      ep_rd_o = '0;
      for (int n = 0; n < NUM_EP; n++)
         ep_rd_o[n] = w_pop && r_sel == 4'(n + 1);
   end
   assign txdat_o     = r_state == SEND ? w_dat : 8'd0;
   assign txdat_len_o = r_len;
   assign txcork_o    = r_cork;
   assign abort_o     = r_abort;
   assign overpop_o   = r_overpop;
   always_ff @(posedge PHY_CLKOUT or posedge RESET) begin
      if (RESET) begin
         r_state   <= IDLE;
         r_sel     <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_cork    <= 1'b1;
         r_abort   <= 1'b0;
         r_overpop <= 1'b0;
      end else if (usbrst_i) begin
         r_state   <= IDLE;
         r_sel     <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_cork    <= 1'b1;
         r_abort   <= 1'b0;
         r_overpop <= 1'b0;
      end else begin
         r_abort <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cork <= w_cork;
               r_len  <= w_len;
               if (txact_i) begin
                  r_sel   <= endpt_i;
                  r_state <= SEND;
               end
            end
            SEND: begin
               if (w_pop)
                  r_cnt <= r_cnt + 12'd1;
               if (txpop_i && r_cnt >= r_len)
                  r_overpop <= 1'b1;
               // a pktfin coinciding with txact falling counts as success
               if (txpktfin_i || !txact_i) begin
                  r_state <= DONE;
                  r_cork  <= 1'b1;
                  r_abort <= !txpktfin_i;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_cork  <= w_cork;
               r_len   <= w_len;
               r_state <= IDLE;
            end
         endcase
      end
   end
`ifdef USB_TX_ZLP_EN
   logic [NUM_EP-1:0] r_zlp;
   logic [11:0]       w_sel_lvl;
   logic              w_sel_eot;
   always_comb begin
      w_sel_lvl = '0;
      w_sel_eot = 1'b0;
      for (int n = 0; n < NUM_EP; n++)
         if (r_sel == 4'(n + 1)) begin
            w_sel_lvl = ep_level_i[12*n +: 12];
            w_sel_eot = ep_eot_i[n];
         end
   end
   // a pending ZLP has len 0, so its own pktfin never re-arms the flag
   always_ff @(posedge PHY_CLKOUT or posedge RESET) begin
      if (RESET)
         r_zlp <= '0;
      else if (usbrst_i)
         r_zlp <= '0;
      else if (r_state == SEND && txpktfin_i)
         for (int n = 0; n < NUM_EP; n++)
            if (r_sel == 4'(n + 1))
               r_zlp[n] <= r_len == w_mp && w_sel_eot && w_sel_lvl == 12'd0;
   end
   assign w_zlp_vec = r_zlp;
`else
   assign w_zlp_vec = '0;
`endif
endmodule

// File: tb/tb_usb_ep_tx_scheduler.sv
// tb_usb_ep_tx_scheduler: directed stimulus with a pop/abort scoreboard for usb_ep_tx_scheduler.
// Build with USB_TX_ZLP_EN defined to exercise the zero-length-packet path.
module tb_usb_ep_tx_scheduler;
   localparam int NUM_EP = 3;
   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 usbrst = 1'b0, hs = 1'b0, txact = 1'b0, txpop = 1'b0, txpktfin = 1'b0;
   logic [3:0]           endpt = '0;
   logic [12*NUM_EP-1:0] level = '0;
   logic [NUM_EP-1:0]    eot = '0;
   logic [8*NUM_EP-1:0]  rdat;
   logic [NUM_EP-1:0]    ep_rd;
   logic [7:0]           txdat;
   logic [11:0]          txlen;
   logic                 cork, abort, overpop;
   typedef struct {int ep; logic [7:0] dat;} pop_t;
   pop_t                 exp_q[$];
   int                   exp_abort = 0;
   int                   nexp[NUM_EP] = '{0, 0, 0};
   int                   n_chk = 0, n_fail = 0;
   logic [NUM_EP-1:0][7:0] fcnt;

   usb_ep_tx_scheduler #(.NUM_EP(NUM_EP), .MAXPKT_HS(512), .MAXPKT_FS(64)) dut (
      .PHY_CLKOUT(clk), .RESET(rst), .usbrst_i(usbrst), .highspeed_i(hs), .endpt_i(endpt),
      .txact_i(txact), .txpop_i(txpop), .txpktfin_i(txpktfin), .ep_level_i(level),
      .ep_eot_i(eot), .ep_rdat_i(rdat), .ep_rd_o(ep_rd), .txdat_o(txdat),
      .txdat_len_o(txlen), .txcork_o(cork), .abort_o(abort), .overpop_o(overpop));

   always #5 clk = ~clk;

   // FWFT FIFO model: head byte of endpoint n is 16*(n+1) plus the number of bytes popped so far
   always @(posedge clk)
      for (int n = 0; n < NUM_EP; n++)
         fcnt[n] <= rst ? 8'd0 : fcnt[n] + 8'(ep_rd[n]);
   always_comb
      for (int n = 0; n < NUM_EP; n++)
         rdat[8*n +: 8] = 8'((n + 1) * 16) + fcnt[n];

   task automatic chk(input string nm, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pops(input int n, input int cnt, input bit expect_pop);
      for (int i = 0; i < cnt; i++) begin
         txpop = 1'b1;
         if (expect_pop) begin
            exp_q.push_back('{ep: n, dat: 8'((n + 1) * 16 + nexp[n])});
            nexp[n]++;
         end
         tick();
      end
      txpop = 1'b0;
   endtask

   task automatic set_ep(input int n, input int lvl, input bit e);
      level[12*n +: 12] = 12'(lvl);
      eot[n] = e;
   endtask

   task automatic chk_idle(input string nm, input int c, input int l);
      chk({nm, "_cork"}, int'(cork), c);
      chk({nm, "_len"}, int'(txlen), l);
   endtask

   // monitor: every pop strobe must match the head of the expected-pop queue
   always @(negedge clk) begin
      pop_t e;
      if (!rst) begin
         chk("onehot_rd", int'($countones(ep_rd) <= 1), 1);
         for (int n = 0; n < NUM_EP; n++)
            if (ep_rd[n]) begin
               chk("pop_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("pop_ep", n, e.ep);
                  chk("pop_dat", int'(txdat), int'(e.dat));
               end
            end
         if (abort) begin
            chk("abort_expected", int'(exp_abort > 0), 1);
            if (exp_abort > 0) exp_abort--;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_idle("rst", 1, 0);
      chk("rst_abort", int'(abort), 0);
      chk("rst_overpop", int'(overpop), 0);
      chk("rst_rd", int'(ep_rd), 0);
      chk("rst_txdat", int'(txdat), 0);
      rst = 1'b0;
      // FS full packet from ep1
      hs = 1'b0; endpt = 4'd1; set_ep(0, 100, 1'b0);
      tick();
      chk_idle("fs_ep1", 0, 64);
      txact = 1'b1;
      tick();
      pops(0, 64, 1'b1);
      chk_idle("fs_ep1_send", 0, 64);
      txpktfin = 1'b1; txact = 1'b0;
      tick();
      txpktfin = 1'b0;
      chk("fs_ep1_done_cork", int'(cork), 1);
      chk("fs_ep1_no_abort", int'(abort), 0);
      chk("fs_ep1_overpop", int'(overpop), 0);
      tick();
      // HS short level: corked until end-of-transfer
      hs = 1'b1; endpt = 4'd2; set_ep(1, 30, 1'b0);
      tick();
      chk_idle("hs_ep2_noeot", 1, 30);
      eot[1] = 1'b1;
      tick();
      chk_idle("hs_ep2_eot", 0, 30);
      // unmapped endpoints
      set_ep(0, 200, 1'b1); set_ep(1, 200, 1'b1); set_ep(2, 200, 1'b1);
      endpt = 4'd0;
      tick();
      chk_idle("ep0", 1, 0);
      txact = 1'b1;
      tick();
      pops(0, 3, 1'b0);
      chk("ep0_overpop", int'(overpop), 1);
      txpktfin = 1'b1; txact = 1'b0;
      tick();
      txpktfin = 1'b0;
      tick();
      endpt = 4'd5;
      tick();
      chk_idle("ep5", 1, 0);
      usbrst = 1'b1;
      tick();
      usbrst = 1'b0;
      chk("usbrst_overpop_clr", int'(overpop), 0);
      // len 10 with overpop and abort
      hs = 1'b0; endpt = 4'd3; set_ep(2, 10, 1'b1);
      tick();
      chk_idle("ep3_len10", 0, 10);
      txact = 1'b1;
      tick();
      pops(2, 10, 1'b1);
      chk("ep3_no_overpop_at_len", int'(overpop), 0);
      pops(2, 2, 1'b0);
      chk("ep3_overpop", int'(overpop), 1);
      txact = 1'b0; exp_abort++;
      tick();
      chk("ep3_abort_pulse", int'(abort), 1);
      tick();
      chk("ep3_abort_end", int'(abort), 0);
      chk("ep3_overpop_sticky", int'(overpop), 1);
      // bus reset mid-packet
      endpt = 4'd1; set_ep(0, 100, 1'b0);
      tick();
      chk_idle("ep1_again", 0, 64);
      txact = 1'b1;
      tick();
      pops(0, 5, 1'b1);
      usbrst = 1'b1;
      tick();
      chk_idle("usbrst_mid", 1, 0);
      chk("usbrst_mid_overpop", int'(overpop), 0);
      chk("usbrst_mid_abort", int'(abort), 0);
      chk("usbrst_mid_rd", int'(ep_rd), 0);
      usbrst = 1'b0; txact = 1'b0; endpt = 4'd3; set_ep(2, 10, 1'b1);
      tick();
      chk_idle("post_usbrst_ep3", 0, 10);
      txact = 1'b1;
      tick();
      pops(2, 10, 1'b1);
      chk("post_usbrst_cnt_overpop", int'(overpop), 0);
      txpktfin = 1'b1; txact = 1'b0;
      tick();
      txpktfin = 1'b0;
      tick();
      // full-size final packet on ep3
      set_ep(2, 64, 1'b1);
      tick();
      chk_idle("ep3_full", 0, 64);
      txact = 1'b1;
      tick();
      pops(2, 64, 1'b1);
      set_ep(2, 0, 1'b1);
      txpktfin = 1'b1; txact = 1'b0;
      tick();
      txpktfin = 1'b0;
      tick();
      tick();
`ifdef USB_TX_ZLP_EN
      chk_idle("zlp_pending", 0, 0);
      txact = 1'b1;
      tick();
      tick();
      txpktfin = 1'b1; txact = 1'b0;
      tick();
      txpktfin = 1'b0;
      tick();
      tick();
      chk_idle("zlp_cleared", 1, 0);
`else
      chk_idle("no_zlp", 1, 0);
`endif
      tick();
      chk("pop_queue_drained", exp_q.size(), 0);
      chk("abort_queue_drained", exp_abort, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
